multiplier_datapath: RTL and testbench

Register and arithmetic datapath for the 8-bit signed shift-add multiplier. It consumes `Shift_En`, `Add`, `Sub` and `Clr_Ld` from the multiplier control unit, and returns the current multiplier LSB `M` that the control unit branches on. It holds sign-extension bit X, accumulator A and multiplier B. After the 8-shift sequence, the 16-bit two's-complement product sits in A:B. Outputs feed the hex display drivers and LEDs at the top level.

---
 rtl/multiplier_datapath.sv | 109 ++++++++++
 tb/tb_multiplier_datapath.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/multiplier_datapath.sv
// Register and arithmetic datapath of the 8-bit signed shift-add multiplier.
// Holds X:A:B and a saturating shift count; product ends up in A:B after 8 shifts.
module multiplier_datapath (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Clr_Ld,
  input  logic       Clr_AX,
  input  logic       Add,
  input  logic       Sub,
  input  logic       Shift_En,
  input  logic [7:0] SW,
  output logic       M,
  output logic       X,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic [3:0] Shift_Cnt,
  output logic       Done
);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR_LD,
    OP_CLR_AX,
    OP_SUB,
    OP_ADD,
    OP_SHIFT
  } op_e;

  localparam logic [3:0] CNT_MAX = 4'd8;

  op_e        op;
  logic       x_q, x_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] cnt_q, cnt_d;
  logic [8:0] sum;
  logic [8:0] diff;

  // One action per cycle; the first asserted strobe in this order wins.
  always_comb begin
    op = OP_HOLD;
    if (Clr_Ld)        op = OP_CLR_LD;
    else if (Clr_AX)   op = OP_CLR_AX;
    else if (Sub)      op = OP_SUB;
    else if (Add)      op = OP_ADD;
    else if (Shift_En) op = OP_SHIFT;
  end

  // 9-bit sign-extended arithmetic so X:A always holds the true partial product.
  assign sum  = {a_q[7], a_q} + {SW[7], SW};
  assign diff = {a_q[7], a_q} + ~{SW[7], SW} + 9'd1;

  always_comb begin
    x_d   = x_q;
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    unique case (op)
      OP_CLR_LD: begin
        x_d   = 1'b0;
        a_d   = 8'h00;
        b_d   = SW;
        cnt_d = 4'd0;
      end
      OP_CLR_AX: begin
        x_d   = 1'b0;
        a_d   = 8'h00;
        cnt_d = 4'd0;
      end
      OP_SUB: begin
        x_d = diff[8];
        a_d = diff[7:0];
      end
      OP_ADD: begin
        x_d = sum[8];
        a_d = sum[7:0];
      end
      OP_SHIFT: begin
        a_d = {x_q, a_q[7:1]};
        b_d = {a_q[0], b_q[7:1]};
        // Registers keep shifting past 8; only the count saturates.
        if (cnt_q < CNT_MAX) cnt_d = cnt_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q   <= 1'b0;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      cnt_q <= 4'd0;
    end else begin
      x_q   <= x_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign M         = b_q[0];
  assign X         = x_q;
  assign Aval      = a_q;
  assign Bval      = b_q;
  assign Shift_Cnt = cnt_q;
  assign Done      = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_multiplier_datapath.sv
// Directed bench for multiplier_datapath: per-cycle vector table for single
// operations and priority, plus full multiply sequences driven like the control unit.
module tb_multiplier_datapath;

  logic       Clk = 1'b0;
  logic       Reset, Clr_Ld, Clr_AX, Add, Sub, Shift_En;
  logic [7:0] SW;
  logic       M, X, Done;
  logic [7:0] Aval, Bval;
  logic [3:0] Shift_Cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  multiplier_datapath dut (
    .Clk(Clk), .Reset(Reset), .Clr_Ld(Clr_Ld), .Clr_AX(Clr_AX),
    .Add(Add), .Sub(Sub), .Shift_En(Shift_En), .SW(SW),
    .M(M), .X(X), .Aval(Aval), .Bval(Bval),
    .Shift_Cnt(Shift_Cnt), .Done(Done)
  );

  typedef struct packed {
    logic       rst, cld, cax, add, sub, sh;
    logic [7:0] sw;
    logic       ex;
    logic [7:0] ea, eb;
    logic [3:0] ec;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of strobes, then sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic cld, input logic cax,
                      input logic add, input logic sub, input logic sh,
                      input logic [7:0] sw);
    Reset = rst; Clr_Ld = cld; Clr_AX = cax;
    Add = add; Sub = sub; Shift_En = sh; SW = sw;
    @(posedge Clk);
    #1;
    Reset = 0; Clr_Ld = 0; Clr_AX = 0; Add = 0; Sub = 0; Shift_En = 0;
  endtask

  // Control-unit style run: add (sub on the 8th bit) when M=1, then shift.
  task automatic run_seq(input logic [7:0] s);
    for (int i = 0; i < 8; i++) begin
      if (M) step(0, 0, 0, (i != 7), (i == 7), 0, s);
      step(0, 0, 0, 0, 0, 1, s);
      if (i == 6) begin
        check("cnt_after_7", {12'd0, Shift_Cnt}, 16'd7);
        check("done_after_7", {15'd0, Done}, 16'd0);
      end
    end
  endtask

  task automatic check_product(input string name, input logic [15:0] prod, input logic ex);
    check({name, "_AB"}, {Aval, Bval}, prod);
    check({name, "_X"}, {15'd0, X}, {15'd0, ex});
    check({name, "_cnt"}, {12'd0, Shift_Cnt}, 16'd8);
    check({name, "_done"}, {15'd0, Done}, 16'd1);
  endtask

  initial begin
    Reset = 1; Clr_Ld = 0; Clr_AX = 0; Add = 0; Sub = 0; Shift_En = 0; SW = 8'h00;

    //            rst cld cax add sub sh  sw     ex  ea     eb     ec
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 8'hAA, 1'b0, 8'h00, 8'hAA, 4'd0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 8'h80, 1'b1, 8'h80, 8'hAA, 4'd0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 8'hD5, 1'b1, 8'h55, 8'hAA, 4'd0};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 8'hD5, 1'b0, 8'h00, 8'h00, 4'd0};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h5A, 1'b0, 8'h00, 8'h5A, 4'd0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 8'h10, 1'b0, 8'h10, 8'h5A, 4'd0};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 8'h01, 1'b0, 8'h11, 8'h5A, 4'd0};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 8'h3C, 1'b0, 8'h00, 8'h3C, 4'd0};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 8'h3C, 1'b0, 8'h00, 8'h1E, 4'd1};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 8'h01, 1'b1, 8'hFF, 8'h1E, 4'd1};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 8'h01, 1'b1, 8'hFF, 8'h8F, 4'd2};
    vecs[12] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 8'h01, 1'b0, 8'h00, 8'h8F, 4'd0};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 8'h77, 1'b0, 8'h00, 8'h8F, 4'd0};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 8'h70, 1'b0, 8'h70, 8'h8F, 4'd0};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 8'h70, 1'b0, 8'hE0, 8'h8F, 4'd0};

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].cld, vecs[i].cax, vecs[i].add, vecs[i].sub, vecs[i].sh, vecs[i].sw);
      check($sformatf("v%0d_X", i), {15'd0, X}, {15'd0, vecs[i].ex});
      check($sformatf("v%0d_A", i), {8'd0, Aval}, {8'd0, vecs[i].ea});
      check($sformatf("v%0d_B", i), {8'd0, Bval}, {8'd0, vecs[i].eb});
      check($sformatf("v%0d_cnt", i), {12'd0, Shift_Cnt}, {12'd0, vecs[i].ec});
      check($sformatf("v%0d_M", i), {15'd0, M}, {15'd0, vecs[i].eb[0]});
      check($sformatf("v%0d_done", i), {15'd0, Done}, {15'd0, (vecs[i].ec == 4'd8)});
    end

    // 3 x 7, then consecutive run 0x15 x 2, then a 9th shift
    step(0, 1, 0, 0, 0, 0, 8'h03);
    run_seq(8'h07);
    check_product("p3x7", 16'h0015, 1'b0);
    step(0, 0, 1, 0, 0, 0, 8'h02);
    check("clr_ax_cnt", {12'd0, Shift_Cnt}, 16'd0);
    check("clr_ax_B", {8'd0, Bval}, 16'h0015);
    run_seq(8'h02);
    check_product("consec", 16'h002A, 1'b0);
    step(0, 0, 0, 0, 0, 1, 8'h02);
    check("sat_cnt", {12'd0, Shift_Cnt}, 16'd8);
    check("sat_AB", {Aval, Bval}, 16'h0015);

    // 3 x -7
    step(0, 1, 0, 0, 0, 0, 8'h03);
    run_seq(8'hF9);
    check_product("p3xm7", 16'hFFEB, 1'b1);

    // -3 x 7 (final Sub)
    step(0, 1, 0, 0, 0, 0, 8'hFD);
    run_seq(8'h07);
    check_product("pm3x7", 16'hFFEB, 1'b1);

    // -128 x -128
    step(0, 1, 0, 0, 0, 0, 8'h80);
    run_seq(8'h80);
    check_product("pm128", 16'h4000, 1'b0);

    // Reset mid-run clears everything
    step(0, 0, 0, 1, 0, 0, 8'h33);
    step(1, 0, 0, 0, 0, 1, 8'h33);
    check("midrst_AB", {Aval, Bval}, 16'h0000);
    check("midrst_cnt", {12'd0, Shift_Cnt}, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
